// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared 4-bit carry-look-ahead helpers for the pipelined adder
package cla_pkg;

    localparam int NIBBLE = 4;

    typedef struct packed {
        logic       c4;
        logic       c3;
        logic [3:0] s;
    } nib_res_t;

    // Every carry is a flat sum of products of g/p and cin, so no carry waits on another
    function automatic nib_res_t cla_nibble(
        input logic [3:0] a4,
        input logic [3:0] b4,
        input logic       cin
    );
        logic [3:0] p;
        logic [3:0] g;
        logic [4:0] c;
        nib_res_t   r;
        p    = a4 ^ b4;
        g    = a4 & b4;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
        r.c4 = c[4];
        r.c3 = c[3];
        r.s  = p ^ c[3:0];
        return r;
    endfunction

    function automatic int stages(input int width);
        return width / NIBBLE;
    endfunction

endpackage

// File: rtl/cla_pipe_stage.sv
// rtl/cla_pipe_stage.sv - one nibble of the pipelined adder with its valid/carry/data registers
// PIPELINED_CLA_ADDER_OVF_EN adds c_msb, the captured carry into the MSB (last stage only).
module cla_pipe_stage
    import cla_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int K     = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_valid,
    input  logic             up_carry,
    input  logic [WIDTH-1:0] up_a,
    input  logic [WIDTH-1:0] up_b,
    input  logic             down_ready,
    output logic             stage_ready,
    output logic             v,
    output logic             cr,
    output logic [WIDTH-1:0] q_a,
    output logic [WIDTH-1:0] q_b
`ifdef PIPELINED_CLA_ADDER_OVF_EN
    ,
    output logic             c_msb
`endif
);

    localparam int LO   = K * NIBBLE;
    localparam bit LAST = (LO + NIBBLE == WIDTH);

    nib_res_t         nib;
    logic [WIDTH-1:0] a_next;
    logic             load;
    logic             unused_c3;

    assign stage_ready = down_ready | ~v;
    assign load        = stage_ready & up_valid;
    assign nib         = cla_nibble(up_a[LO +: NIBBLE], up_b[LO +: NIBBLE], up_carry);
    assign unused_c3   = nib.c3;

    // up_a carries finished sum bits below LO and pending operand A above it
    always_comb begin
        a_next               = up_a;
        a_next[LO +: NIBBLE] = nib.s;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v   <= 1'b0;
            cr  <= 1'b0;
            q_a <= '0;
        end else if (stage_ready) begin
            v <= up_valid;
            if (up_valid) begin
                cr  <= nib.c4;
                q_a <= a_next;
            end
        end
    end

    generate
        if (LAST) begin : g_last
            assign q_b = '0;
        end else begin : g_pend
            logic [WIDTH-LO-NIBBLE-1:0] b_pend;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    b_pend <= '0;
                end else if (load) begin
                    b_pend <= up_b[WIDTH-1:LO+NIBBLE];
                end
            end
            assign q_b = {b_pend, {(LO + NIBBLE){1'b0}}};
        end

        if (K > 0) begin : g_low
            logic unused_low_b;
            assign unused_low_b = ^up_b[LO-1:0];
        end

`ifdef PIPELINED_CLA_ADDER_OVF_EN
        if (LAST) begin : g_msb
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    c_msb <= 1'b0;
                end else if (load) begin
                    c_msb <= nib.c3;
                end
            end
        end else begin : g_no_msb
            assign c_msb = 1'b0;
        end
`endif
    endgenerate

endmodule

// File: rtl/pipelined_cla_adder.sv
// rtl/pipelined_cla_adder.sv - WIDTH-bit adder, one registered 4-bit CLA slice per stage, valid/ready both sides
// PIPELINED_CLA_ADDER_OVF_EN adds the ovf (two's-complement overflow) output.
module pipelined_cla_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
`ifdef PIPELINED_CLA_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int STAGES = stages(WIDTH);

    // Index 0 is the input side; index k+1 is the register output of stage k
    logic [STAGES:0]   chain_v;
    logic [STAGES:0]   chain_c;
    logic [WIDTH-1:0]  chain_a [STAGES+1];
    logic [WIDTH-1:0]  chain_b [STAGES+1];
    logic [STAGES-1:0] down_rdy;
    logic [STAGES-1:0] stage_rdy;
    logic              unused_ok;
`ifdef PIPELINED_CLA_ADDER_OVF_EN
    logic [STAGES-1:0] c_msb_w;
`endif

    assign chain_v[0] = in_valid;
    assign chain_c[0] = c_in;
    assign chain_a[0] = a;
    assign chain_b[0] = b;

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_stage
            // Unrolled ready chain: a stage can advance unless everything downstream is full and stalled
            if (k == STAGES - 1) begin : g_tail
                assign down_rdy[k] = out_ready;
            end else begin : g_body
                assign down_rdy[k] = out_ready | ~(&chain_v[STAGES:k+2]);
            end

            cla_pipe_stage #(
                .WIDTH (WIDTH),
                .K     (k)
            ) u_stage (
                .clk         (clk),
                .rst         (rst),
                .up_valid    (chain_v[k]),
                .up_carry    (chain_c[k]),
                .up_a        (chain_a[k]),
                .up_b        (chain_b[k]),
                .down_ready  (down_rdy[k]),
                .stage_ready (stage_rdy[k]),
                .v           (chain_v[k+1]),
                .cr          (chain_c[k+1]),
                .q_a         (chain_a[k+1]),
                .q_b         (chain_b[k+1])
`ifdef PIPELINED_CLA_ADDER_OVF_EN
                ,
                .c_msb       (c_msb_w[k])
`endif
            );
        end
    endgenerate

    assign in_ready  = stage_rdy[0];
    assign out_valid = chain_v[STAGES];
    assign sum       = chain_a[STAGES];
    assign c_out     = chain_c[STAGES];

`ifdef PIPELINED_CLA_ADDER_OVF_EN
    assign ovf       = c_msb_w[STAGES-1] ^ chain_c[STAGES];
    assign unused_ok = ^{chain_b[STAGES], stage_rdy, c_msb_w};
`else
    assign unused_ok = ^{chain_b[STAGES], stage_rdy};
`endif

endmodule
